// File: rtl/reg_access_sequencer.sv
// Burst command sequencer between the host word stream and the 32x32 register block.
// Drives reg_num_le / wr_en / rd_en with auto-incrementing register numbers and returns readback plus a status trailer.
module reg_access_sequencer #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] reg_rx_data,
  output logic        reg_num_le,
  output logic        wr_en,
  output logic        rd_en,
  input  logic [31:0] reg_tx_data,
  input  logic        illegal_reg_num,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, LOAD, CHECK, WDATA, WR, RD, RWAIT, RSP, DRAIN, STATUS
  } state_t;

  localparam logic [7:0] LAT_LAST = 8'(RD_LATENCY - 1);

  state_t      state;
  logic        rw;
  logic [7:0]  count;
  logic [7:0]  done;
  logic [7:0]  cnt;
  logic [15:0] reg_num;
  logic [3:0]  err;
  logic        cmd_fire;
  logic        rsp_fire;
  logic [7:0]  next_done;
  logic        last;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign next_done = done + 8'd1;
  assign last      = (next_done == count);

  function automatic logic [31:0] status_word(input logic rw_f, input logic [7:0] done_f,
                                              input logic [3:0] err_f);
    return {4'hF, rw_f, 3'b000, done_f, 12'h000, err_f};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 32'h0;
      reg_rx_data <= 32'h0;
      reg_num_le  <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      rw          <= 1'b0;
      count       <= 8'h0;
      done        <= 8'h0;
      cnt         <= 8'h0;
      reg_num     <= 16'h0;
      err         <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rw        <= cmd_data[31];
            count     <= cmd_data[23:16];
            reg_num   <= cmd_data[15:0];
            done      <= 8'h0;
            if (cmd_data[30:24] != 7'd0) begin
              err       <= 4'd3;
              rsp_valid <= 1'b1;
              rsp_data  <= status_word(cmd_data[31], 8'h0, 4'd3);
              state     <= STATUS;
            end else if (cmd_data[23:16] == 8'd0) begin
              err       <= 4'd1;
              rsp_valid <= 1'b1;
              rsp_data  <= status_word(cmd_data[31], 8'h0, 4'd1);
              state     <= STATUS;
            end else begin
              err         <= 4'd0;
              reg_num_le  <= 1'b1;
              reg_rx_data <= {16'h0, cmd_data[15:0]};
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          reg_num_le <= 1'b0;
          state      <= CHECK;
        end
        CHECK: begin
          // illegal_reg_num reflects the number latched by the previous cycle's strobe
          if (illegal_reg_num) begin
            err <= 4'd2;
            if (rw) begin
              cmd_ready <= 1'b1;
              cnt       <= count - done;
              state     <= DRAIN;
            end else begin
              rsp_valid <= 1'b1;
              rsp_data  <= status_word(rw, done, 4'd2);
              state     <= STATUS;
            end
          end else if (rw) begin
            cmd_ready <= 1'b1;
            state     <= WDATA;
          end else begin
            rd_en <= 1'b1;
            state <= RD;
          end
        end
        WDATA: begin
          if (cmd_fire) begin
            cmd_ready   <= 1'b0;
            wr_en       <= 1'b1;
            reg_rx_data <= cmd_data;
            state       <= WR;
          end
        end
        WR: begin
          wr_en   <= 1'b0;
          done    <= next_done;
          reg_num <= reg_num + 16'd1;
          if (last) begin
            rsp_valid <= 1'b1;
            rsp_data  <= status_word(rw, next_done, err);
            state     <= STATUS;
          end else begin
            reg_num_le  <= 1'b1;
            reg_rx_data <= {16'h0, reg_num + 16'd1};
            state       <= LOAD;
          end
        end
        RD: begin
          rd_en <= 1'b0;
          cnt   <= LAT_LAST;
          state <= RWAIT;
        end
        RWAIT: begin
          if (cnt == 8'd0) begin
            rsp_data  <= reg_tx_data;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RSP: begin
          if (rsp_fire) begin
            done    <= next_done;
            reg_num <= reg_num + 16'd1;
            if (last) begin
              rsp_data <= status_word(rw, next_done, err);
              state    <= STATUS;
            end else begin
              rsp_valid   <= 1'b0;
              reg_num_le  <= 1'b1;
              reg_rx_data <= {16'h0, reg_num + 16'd1};
              state       <= LOAD;
            end
          end
        end
        DRAIN: begin
          if (cmd_fire) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              cmd_ready <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_data  <= status_word(rw, done, err);
              state     <= STATUS;
            end
          end
        end
        STATUS: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Randomized bench for reg_access_sequencer: register-block model, command-level reference model and per-cycle compare.
// Directed cases pin the model with literal status and readback words.
module tb_reg_access_sequencer;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] reg_rx_data;
  logic        reg_num_le;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] reg_tx_data;
  logic        illegal_reg_num;
  logic        busy;

  always #4 clk = ~clk;

  reg_access_sequencer #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .reg_rx_data(reg_rx_data), .reg_num_le(reg_num_le), .wr_en(wr_en), .rd_en(rd_en),
    .reg_tx_data(reg_tx_data), .illegal_reg_num(illegal_reg_num), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'd70000;
    if (i == 3 || i == 4) return 32'd100;
    return 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  // register block: latched number, write port, read pipeline with garbage when idle
  logic [31:0] regs [0:31];
  logic [15:0] lat_num = 16'h0;
  logic [31:0] pipe [0:LAT-1];

  always @(posedge clk) begin
    if (reg_num_le) lat_num <= reg_rx_data[15:0];
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_word(i);
    end else if (wr_en && lat_num < 16'd32) begin
      regs[lat_num[4:0]] <= reg_rx_data;
    end
    pipe[0] <= (rd_en && lat_num < 16'd32) ? regs[lat_num[4:0]] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign reg_tx_data     = pipe[LAT-1];
  assign illegal_reg_num = (lat_num > 16'd31);

  // reference model state
  logic [31:0] mmem [0:31];
  logic [47:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  logic [32:0] exp_rsp [$];
  logic [31:0] obs_rsp [$];
  logic [31:0] last_status = 32'h0;
  bit          stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual event required none", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mmem[i] = init_word(i);
  endtask

  task automatic run_model(input logic [31:0] hdr, input logic [31:0] d[$]);
    logic        rw;
    logic [7:0]  n;
    logic [7:0]  done;
    logic [3:0]  err;
    logic [15:0] rr;
    rw = hdr[31];
    n = hdr[23:16];
    done = 8'd0;
    err = 4'd0;
    if (hdr[30:24] != 7'd0) err = 4'd3;
    else if (n == 8'd0) err = 4'd1;
    else begin
      for (int i = 0; i < int'(n); i++) begin
        rr = hdr[15:0] + 16'(i);
        if (rr > 16'd31) begin
          err = 4'd2;
          break;
        end
        if (rw) begin
          exp_wr.push_back({rr, d[i]});
          mmem[rr[4:0]] = d[i];
        end else begin
          exp_rd.push_back(rr);
          exp_rsp.push_back({1'b0, mmem[rr[4:0]]});
        end
        done++;
      end
    end
    exp_rsp.push_back({1'b1, 4'hF, rw, 3'b000, done, 12'h000, err});
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok;
    int t;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    cmd_valid = 1'b1;
    cmd_data = w;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 2000) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
      t++;
    end
    cmd_valid = 1'b0;
    cmd_data = $urandom;
    if (!ok) fail("cmd_accept_timeout");
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_rsp.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_rsp.size() != 0) begin
      fail("rsp_drain_timeout");
      exp_rsp.delete();
    end
  endtask

  task automatic wait_rsp_valid();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 200);
    if (!rsp_valid) fail("rsp_valid_timeout");
  endtask

  task automatic do_cmd(input logic [31:0] hdr, input logic [31:0] d[$], input bit wait_done);
    run_model(hdr, d);
    send_word(hdr);
    if (hdr[31] && hdr[30:24] == 7'd0 && hdr[23:16] != 8'd0)
      foreach (d[i]) send_word(d[i]);
    if (wait_done) wait_idle();
  endtask

  task automatic check_obs(input string name, input logic [31:0] e[$]);
    chk({name, "_count"}, obs_rsp.size(), e.size());
    foreach (e[i]) if (i < obs_rsp.size()) chk({name, "_word"}, obs_rsp[i], e[i]);
    obs_rsp.delete();
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // per-cycle compare against model expectations
  bit          held = 1'b0;
  logic [31:0] held_val;
  bit          st_pend = 1'b0;
  bit          p_le = 1'b0, p_wr = 1'b0, p_rd = 1'b0;
  int          nstb;
  logic [47:0] ew;
  logic [15:0] er;
  logic [32:0] es;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0; st_pend = 1'b0; p_le = 1'b0; p_wr = 1'b0; p_rd = 1'b0;
    end else begin
      if (st_pend) begin
        chk("busy_after_status", 32'(busy), 32'd0);
        chk("ready_after_status", 32'(cmd_ready), 32'd1);
      end
      st_pend = 1'b0;
      nstb = int'(reg_num_le) + int'(wr_en) + int'(rd_en);
      if (nstb != 0) begin
        chk("strobe_exclusive", 32'(nstb <= 1), 32'd1);
        chk("strobe_width", 32'((reg_num_le && p_le) || (wr_en && p_wr) || (rd_en && p_rd)), 32'd0);
      end
      if (nstb != 0 || rsp_valid) chk("busy_active", 32'(busy), 32'd1);
      if (wr_en) begin
        if (exp_wr.size() == 0) fail("unexpected_wr_en");
        else begin
          ew = exp_wr.pop_front();
          chk("wr_reg", 32'(lat_num), 32'(ew[47:32]));
          chk("wr_data", reg_rx_data, ew[31:0]);
        end
      end
      if (rd_en) begin
        if (exp_rd.size() == 0) fail("unexpected_rd_en");
        else begin
          er = exp_rd.pop_front();
          chk("rd_reg", 32'(lat_num), 32'(er));
        end
      end
      if (rsp_valid) begin
        chk("cmd_ready_low_in_rsp", 32'(cmd_ready), 32'd0);
        if (held) chk("rsp_hold", rsp_data, held_val);
        if (rsp_ready) begin
          obs_rsp.push_back(rsp_data);
          if (exp_rsp.size() == 0) fail("unexpected_rsp");
          else begin
            es = exp_rsp.pop_front();
            chk("rsp_word", rsp_data, es[31:0]);
            if (es[32]) begin
              last_status = rsp_data;
              st_pend = 1'b1;
            end
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_val = rsp_data;
        end
      end else begin
        held = 1'b0;
      end
      p_le = reg_num_le; p_wr = wr_en; p_rd = rd_en;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] dq [$];
  logic [31:0] eq [$];
  int          nst;
  logic [31:0] hdr;
  logic [7:0]  n;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_strobes", {29'd0, reg_num_le, wr_en, rd_en}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", reg_rx_data, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // read after reset
    dq.delete(); obs_rsp.delete();
    do_cmd(32'h0003_0002, dq, 1'b1);
    eq.delete(); eq.push_back(32'd70000); eq.push_back(32'd100); eq.push_back(32'd100);
    eq.push_back(32'hF003_0000);
    check_obs("read_3", eq);

    // two-word write
    dq.delete(); dq.push_back(32'd5); dq.push_back(32'd200);
    do_cmd(32'h8002_000E, dq, 1'b1);
    eq.delete(); eq.push_back(32'hF802_0000);
    check_obs("write_2", eq);
    chk("reg14", regs[14], 32'd5);
    chk("reg15", regs[15], 32'd200);

    // read running past register 31
    dq.delete();
    do_cmd(32'h0002_001F, dq, 1'b1);
    eq.delete(); eq.push_back(32'h1000_1F1F); eq.push_back(32'hF001_0002);
    check_obs("read_edge", eq);

    // write starting at an illegal register: data drained
    dq.delete(); dq.push_back(32'h1); dq.push_back(32'h2); dq.push_back(32'h3);
    do_cmd(32'h8003_0020, dq, 1'b1);
    eq.delete(); eq.push_back(32'hF800_0002);
    check_obs("write_drain", eq);

    // zero count and reserved bits
    dq.delete();
    do_cmd(32'h0000_0000, dq, 1'b1);
    do_cmd(32'h0101_0000, dq, 1'b1);
    eq.delete(); eq.push_back(32'hF000_0001); eq.push_back(32'hF000_0003);
    check_obs("bad_hdr", eq);

    // hold rsp_ready low mid-read
    stall = 1'b1;
    dq.delete();
    do_cmd(32'h0002_0005, dq, 1'b0);
    wait_rsp_valid();
    nst = 0;
    repeat (10) begin
      @(negedge clk);
      if (reg_num_le || wr_en || rd_en) nst++;
    end
    chk("stall_no_strobe", 32'(nst), 32'd0);
    chk("stall_rsp_data", rsp_data, 32'h1000_0505);
    stall = 1'b0;
    wait_idle();
    eq.delete(); eq.push_back(32'h1000_0505); eq.push_back(32'h1000_0606);
    eq.push_back(32'hF002_0000);
    check_obs("stall_read", eq);

    // reset while a readback word is pending
    stall = 1'b1;
    dq.delete();
    do_cmd(32'h0003_0000, dq, 1'b0);
    wait_rsp_valid();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_wr.delete(); exp_rd.delete(); exp_rsp.delete(); obs_rsp.delete();
    model_reset();
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_strobes", {29'd0, reg_num_le, wr_en, rd_en}, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_data", reg_rx_data, 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    stall = 1'b0;
    dq.delete(); dq.push_back(32'hDEAD_BEEF);
    do_cmd(32'h8001_0007, dq, 1'b1);
    eq.delete(); eq.push_back(32'hF801_0000);
    check_obs("after_reset", eq);
    chk("reg7", regs[7], 32'hDEAD_BEEF);

    // randomized commands, sometimes offered back-to-back while busy
    for (int k = 0; k < 60; k++) begin
      n = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      if ($urandom_range(0, 7) == 0) n = 8'($urandom_range(7, 12));
      hdr = {1'($urandom_range(0, 1)), 7'd0, n, 16'($urandom_range(0, 36))};
      if ($urandom_range(0, 11) == 0) hdr[30:24] = 7'($urandom_range(1, 127));
      dq.delete();
      for (int j = 0; j < int'(n); j++) dq.push_back($urandom);
      do_cmd(hdr, dq, $urandom_range(0, 1) == 1);
    end
    wait_idle();
    repeat (4) @(posedge clk);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
